health_bar_ctrl: RTL and testbench
==================================

HEALTH_BAR_CTRL -- requirements
Module: health_bar_ctrl

Interface
REQ-001 SHALL provide parameter SEGMENTS, default 3, meaning segment count and maximum health; legal range 1..15.
REQ-002 SHALL provide parameter X0, default 420, meaning left pixel column of segment 0.
REQ-003 SHALL provide parameter Y0, default 460, meaning top pixel row of the bar.
REQ-004 SHALL provide parameter SEG_W, default 60, meaning segment width in pixels.
REQ-005 SHALL provide parameter SEG_H, default 10, meaning bar height in pixels.
REQ-006 SHALL provide parameter INVULN_FRAMES, default 60, meaning invulnerability length in frames; legal range 1..1023.
REQ-007 SHALL provide parameter BLINK_FRAMES, default 8, meaning frames per blink half-period; legal range 1..255.
REQ-008 SHALL provide parameters COLOR_FULL, default 12'h00F; COLOR_LOW, default 12'hF00; COLOR_EMPTY, default 12'h333.
REQ-009 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-010 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-011 SHALL provide ports x and y, input, 10 bits each: current scan pixel coordinates.
REQ-012 SHALL provide port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-013 SHALL provide ports hit, heal and restart, input, 1 bit each: single-cycle event pulses.
REQ-014 SHALL provide port health, output, 4 bits: current health, 0..SEGMENTS.
REQ-015 SHALL provide ports dead and invuln, output, 1 bit each: state flags.
REQ-016 SHALL provide port bar_en, output, 1 bit: the current pixel belongs to the bar.
REQ-017 SHALL provide port bar_rgb, output, 12 bits: pixel colour, 4 bits per channel, R in [11:8].

Function
REQ-018 SHALL implement states ALIVE, INVULN and DEAD; dead=1 only in DEAD; invuln=1 only in INVULN.
REQ-019 Event priority SHALL be restart > hit > heal; lower-priority events in the same cycle are dropped.
REQ-020 restart in any state SHALL set health=SEGMENTS, state=ALIVE, invuln counter=0 and blink phase=0 on the next edge.
REQ-021 hit in ALIVE with health>1 SHALL decrement health, enter INVULN and load the invuln counter with INVULN_FRAMES.
REQ-022 hit in ALIVE with health==1 SHALL set health=0 and enter DEAD.
REQ-023 hit in INVULN or DEAD SHALL be ignored.
REQ-024 heal in ALIVE or INVULN SHALL increment health, saturating at SEGMENTS; heal SHALL NOT change state or the counter.
REQ-025 heal in DEAD SHALL be ignored; only restart or rst leaves DEAD.
REQ-026 In INVULN, each frame_tick SHALL decrement the counter; the tick that takes it from 1 to 0 SHALL move the state to ALIVE on the same edge.
REQ-027 The blink counter SHALL advance only on frame_tick in INVULN and toggle the blink phase every BLINK_FRAMES ticks; both SHALL clear on entering INVULN and on leaving it.
REQ-028 Segment i (0-based) SHALL occupy X0+i*SEG_W <= x < X0+(i+1)*SEG_W and Y0 <= y < Y0+SEG_H; bounds are half-open, so adjacent segments never overlap.
REQ-029 Segment i SHALL be lit when health > i; otherwise it is empty.
REQ-030 Lit colour SHALL be COLOR_LOW when health==1 and SEGMENTS>1; otherwise COLOR_FULL.
REQ-031 In INVULN with blink phase=1, lit segments SHALL render as COLOR_EMPTY.
REQ-032 Empty segments SHALL render COLOR_EMPTY with bar_en=1.
REQ-033 bar_en and bar_rgb SHALL be registered: they correspond to x and y sampled one clk earlier, a latency of exactly 1 cycle.
REQ-034 bar_rgb SHALL be 12'h000 whenever bar_en=0.
REQ-035 Segment-region arithmetic SHALL be at least 11 bits wide so that X0+SEGMENTS*SEG_W up to 2047 does not wrap.
REQ-036 health, dead and invuln SHALL be driven directly from state registers, with no combinational path from inputs.

Reset
REQ-037 While rst=1, registers SHALL immediately hold health=SEGMENTS, state ALIVE, counters 0, blink phase 0, bar_en=0 and bar_rgb=0.
REQ-038 rst asserted mid-INVULN or while in DEAD SHALL abort to the reset values with no residual timing.
REQ-039 The first edge after rst deasserts SHALL process inputs normally.

Verification
REQ-040 Defaults; hit; then 60 frame_ticks -> health=2, invuln=1 until the 60th tick edge, then invuln=0.
REQ-041 Three hits, each issued after invulnerability expires -> health goes 2, 1, 0; dead=1 after the third; a 4th hit and a heal leave health=0.
REQ-042 hit and heal in the same cycle in ALIVE at health=3 -> health=2 and INVULN; heal at health=3 -> stays 3.
REQ-043 Pixel sweep at health=1, x=419..601, y=465 -> bar_en=1 exactly for x=420..599 one cycle later; bar_rgb=12'hF00 for x=420..479 and 12'h333 for x=480..599.
REQ-044 During INVULN, pixel (430,465) -> bar_rgb alternates between COLOR_FULL and 12'h333 every 8 frame_ticks.
REQ-045 restart with hit in the same cycle while in DEAD, and rst pulsed mid-INVULN -> both give health=3, ALIVE, dead=0, invuln=0.

Source files
------------

// File: rtl/health_bar_ctrl.sv
// Health bar: hit/heal/restart state machine with timed invulnerability and blink,
// plus a segmented bar renderer whose pixel outputs are registered (1-cycle latency).
module health_bar_ctrl #(
    parameter int          SEGMENTS      = 3,
    parameter int          X0            = 420,
    parameter int          Y0            = 460,
    parameter int          SEG_W         = 60,
    parameter int          SEG_H         = 10,
    parameter int          INVULN_FRAMES = 60,
    parameter int          BLINK_FRAMES  = 8,
    parameter logic [11:0] COLOR_FULL    = 12'h00F,
    parameter logic [11:0] COLOR_LOW     = 12'hF00,
    parameter logic [11:0] COLOR_EMPTY   = 12'h333
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic        heal,
    input  logic        restart,
    output logic [3:0]  health,
    output logic        dead,
    output logic        invuln,
    output logic        bar_en,
    output logic [11:0] bar_rgb
);

    typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

    localparam logic [3:0] HEALTH_MAX = 4'(SEGMENTS);
    localparam logic [9:0] INV_LOAD   = 10'(INVULN_FRAMES);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    state_t      state_q, state_d;
    logic [3:0]  health_q, health_d;
    logic [9:0]  inv_cnt_q, inv_cnt_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;
    logic        bar_en_q, bar_en_d;
    logic [11:0] bar_rgb_q, bar_rgb_d;
    logic        seg_lit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ALIVE;
            health_q    <= HEALTH_MAX;
            inv_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            bar_en_q    <= 1'b0;
            bar_rgb_q   <= 12'h000;
        end else begin
            state_q     <= state_d;
            health_q    <= health_d;
            inv_cnt_q   <= inv_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            bar_en_q    <= bar_en_d;
            bar_rgb_q   <= bar_rgb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        health_d    = health_q;
        inv_cnt_d   = inv_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (restart) begin
            state_d     = ALIVE;
            health_d    = HEALTH_MAX;
            inv_cnt_d   = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else begin
            // Frame timing runs independently of hit/heal; a hit here is ignored anyway.
            if (state_q == INVULN && frame_tick) begin
                if (inv_cnt_q == 10'd1) begin
                    state_d     = ALIVE;
                    inv_cnt_d   = '0;
                    blink_cnt_d = '0;
                    blink_d     = 1'b0;
                end else begin
                    inv_cnt_d = inv_cnt_q - 10'd1;
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 8'd1;
                    end
                end
            end
            if (hit) begin
                if (state_q == ALIVE) begin
                    if (health_q > 4'd1) begin
                        health_d    = health_q - 4'd1;
                        state_d     = INVULN;
                        inv_cnt_d   = INV_LOAD;
                        blink_cnt_d = '0;
                        blink_d     = 1'b0;
                    end else begin
                        health_d = 4'd0;
                        state_d  = DEAD;
                    end
                end
            end else if (heal && state_q != DEAD && health_q != HEALTH_MAX) begin
                health_d = health_q + 4'd1;
            end
        end
    end

    // Pixel classification uses 32-bit int arithmetic so large bar extents never wrap.
    always_comb begin
        bar_en_d  = 1'b0;
        seg_lit   = 1'b0;
        bar_rgb_d = 12'h000;
        if (int'(y) >= Y0 && int'(y) < Y0 + SEG_H) begin
            for (int i = 0; i < SEGMENTS; i++) begin
                if (int'(x) >= X0 + i * SEG_W && int'(x) < X0 + (i + 1) * SEG_W) begin
                    bar_en_d = 1'b1;
                    seg_lit  = int'(health_q) > i;
                end
            end
        end
        if (bar_en_d) begin
            if (seg_lit && !(state_q == INVULN && blink_q))
                bar_rgb_d = (health_q == 4'd1 && SEGMENTS > 1) ? COLOR_LOW : COLOR_FULL;
            else
                bar_rgb_d = COLOR_EMPTY;
        end
    end

    always_comb begin
        health  = health_q;
        dead    = (state_q == DEAD);
        invuln  = (state_q == INVULN);
        bar_en  = bar_en_q;
        bar_rgb = bar_rgb_q;
    end

endmodule

// File: tb/tb_health_bar_ctrl.sv
// Directed bench for health_bar_ctrl: inputs change on the falling edge, outputs checked there too.
module tb_health_bar_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x, y;
    logic        frame_tick, hit, heal, restart;
    logic [3:0]  health;
    logic        dead, invuln, bar_en;
    logic [11:0] bar_rgb;

    int n_cmp = 0;
    int n_err = 0;

    health_bar_ctrl dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .frame_tick(frame_tick),
        .hit(hit), .heal(heal), .restart(restart), .health(health),
        .dead(dead), .invuln(invuln), .bar_en(bar_en), .bar_rgb(bar_rgb)
    );

    always #5 clk = ~clk;

    // One clock edge with the given event pulses; returns on the following falling edge.
    task automatic cycle(input logic h, input logic he, input logic r, input logic ft);
        hit = h; heal = he; restart = r; frame_tick = ft;
        @(negedge clk);
        hit = 1'b0; heal = 1'b0; restart = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1; x = 10'd430; y = 10'd465;
        repeat (2) @(negedge clk);
        n_cmp++; if (health !== 4'd3) begin n_err++; $display("FAIL reset_health: got %0d, expected 3", health); end
        n_cmp++; if (dead !== 1'b0 || invuln !== 1'b0) begin n_err++; $display("FAIL reset_flags: got dead=%b invuln=%b, expected 0 0", dead, invuln); end
        n_cmp++; if (bar_en !== 1'b0 || bar_rgb !== 12'h000) begin n_err++; $display("FAIL reset_pixel: got en=%b rgb=%h, expected 0 000", bar_en, bar_rgb); end
        rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (health !== 4'd2 || invuln !== 1'b1) begin n_err++; $display("FAIL first_edge_hit: got health=%0d invuln=%b, expected 2 1", health, invuln); end
    endtask

    task automatic test_invuln_timer;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (health !== 4'd2 || invuln !== 1'b1) begin n_err++; $display("FAIL timer_hit: got health=%0d invuln=%b, expected 2 1", health, invuln); end
        for (int k = 1; k < 60; k++) begin
            frames(1);
            n_cmp++; if (invuln !== 1'b1) begin n_err++; $display("FAIL timer_tick%0d: got invuln=%b, expected 1", k, invuln); end
        end
        frames(1);
        n_cmp++; if (invuln !== 1'b0 || health !== 4'd2 || dead !== 1'b0) begin n_err++; $display("FAIL timer_expire: got invuln=%b health=%0d dead=%b, expected 0 2 0", invuln, health, dead); end
    endtask

    task automatic test_hits_to_death;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (health !== 4'd2) begin n_err++; $display("FAIL death_hit1: got %0d, expected 2", health); end
        frames(60);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (health !== 4'd1 || invuln !== 1'b1) begin n_err++; $display("FAIL death_hit2: got health=%0d invuln=%b, expected 1 1", health, invuln); end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (health !== 4'd1) begin n_err++; $display("FAIL hit_in_invuln: got %0d, expected 1", health); end
        frames(60);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (health !== 4'd0 || dead !== 1'b1 || invuln !== 1'b0) begin n_err++; $display("FAIL death_hit3: got health=%0d dead=%b invuln=%b, expected 0 1 0", health, dead, invuln); end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (health !== 4'd0 || dead !== 1'b1) begin n_err++; $display("FAIL dead_sticky: got health=%0d dead=%b, expected 0 1", health, dead); end
    endtask

    task automatic test_priority;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (health !== 4'd2 || invuln !== 1'b1) begin n_err++; $display("FAIL hit_over_heal: got health=%0d invuln=%b, expected 2 1", health, invuln); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (health !== 4'd3 || invuln !== 1'b1) begin n_err++; $display("FAIL heal_in_invuln: got health=%0d invuln=%b, expected 3 1", health, invuln); end
        frames(59);
        n_cmp++; if (invuln !== 1'b1) begin n_err++; $display("FAIL heal_keeps_counter: got invuln=%b, expected 1", invuln); end
        frames(1);
        n_cmp++; if (invuln !== 1'b0) begin n_err++; $display("FAIL heal_counter_expire: got invuln=%b, expected 0", invuln); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (health !== 4'd3) begin n_err++; $display("FAIL heal_saturate: got %0d, expected 3", health); end
    endtask

    task automatic test_pixel_sweep;
        logic        exp_en;
        logic [11:0] exp_rgb;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        y = 10'd465;
        x = 10'd479; cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bar_rgb !== 12'h00F) begin n_err++; $display("FAIL full_seg0_edge: got %h, expected 00F", bar_rgb); end
        x = 10'd599; cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bar_rgb !== 12'h00F) begin n_err++; $display("FAIL full_seg2_edge: got %h, expected 00F", bar_rgb); end
        cycle(1'b1, 1'b0, 1'b0, 1'b0); frames(60);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); frames(60);
        n_cmp++; if (health !== 4'd1 || invuln !== 1'b0) begin n_err++; $display("FAIL sweep_setup: got health=%0d invuln=%b, expected 1 0", health, invuln); end
        for (int px = 419; px <= 601; px++) begin
            x = 10'(px);
            @(negedge clk);
            exp_en  = (px >= 420 && px <= 599);
            exp_rgb = !exp_en ? 12'h000 : (px < 480 ? 12'hF00 : 12'h333);
            n_cmp++; if (bar_en !== exp_en || bar_rgb !== exp_rgb) begin n_err++; $display("FAIL sweep_x%0d: got en=%b rgb=%h, expected en=%b rgb=%h", px, bar_en, bar_rgb, exp_en, exp_rgb); end
        end
        x = 10'd430; y = 10'd459; @(negedge clk);
        n_cmp++; if (bar_en !== 1'b0) begin n_err++; $display("FAIL y_above: got en=%b, expected 0", bar_en); end
        y = 10'd469; @(negedge clk);
        n_cmp++; if (bar_en !== 1'b1 || bar_rgb !== 12'hF00) begin n_err++; $display("FAIL y_last_row: got en=%b rgb=%h, expected 1 F00", bar_en, bar_rgb); end
        y = 10'd470; @(negedge clk);
        n_cmp++; if (bar_en !== 1'b0 || bar_rgb !== 12'h000) begin n_err++; $display("FAIL y_below: got en=%b rgb=%h, expected 0 000", bar_en, bar_rgb); end
    endtask

    task automatic test_blink;
        logic [11:0] exp_rgb;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        x = 10'd430; y = 10'd465;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            frames(1);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            exp_rgb = ((k / 8) % 2 == 1) ? 12'h333 : 12'h00F;
            n_cmp++; if (bar_rgb !== exp_rgb) begin n_err++; $display("FAIL blink_tick%0d: got %h, expected %h", k, bar_rgb, exp_rgb); end
        end
        frames(36);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (invuln !== 1'b0 || bar_rgb !== 12'h00F) begin n_err++; $display("FAIL blink_cleared: got invuln=%b rgb=%h, expected 0 00F", invuln, bar_rgb); end
    endtask

    task automatic test_restart_dead;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); frames(60);
        cycle(1'b1, 1'b0, 1'b0, 1'b0); frames(60);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (dead !== 1'b1) begin n_err++; $display("FAIL restart_setup: got dead=%b, expected 1", dead); end
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (health !== 4'd3 || dead !== 1'b0 || invuln !== 1'b0) begin n_err++; $display("FAIL restart_over_hit: got health=%0d dead=%b invuln=%b, expected 3 0 0", health, dead, invuln); end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (health !== 4'd2 || invuln !== 1'b1) begin n_err++; $display("FAIL alive_after_restart: got health=%0d invuln=%b, expected 2 1", health, invuln); end
    endtask

    task automatic test_rst_mid_invuln;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        frames(10);
        rst = 1'b1;
        #1;
        n_cmp++; if (health !== 4'd3 || invuln !== 1'b0 || dead !== 1'b0) begin n_err++; $display("FAIL async_rst: got health=%0d invuln=%b dead=%b, expected 3 0 0", health, invuln, dead); end
        @(negedge clk);
        rst = 1'b0;
        frames(3);
        n_cmp++; if (invuln !== 1'b0 || health !== 4'd3) begin n_err++; $display("FAIL rst_no_residual: got invuln=%b health=%0d, expected 0 3", invuln, health); end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        frames(59);
        n_cmp++; if (invuln !== 1'b1 || health !== 4'd2) begin n_err++; $display("FAIL rst_reinvuln: got invuln=%b health=%0d, expected 1 2", invuln, health); end
        frames(1);
        n_cmp++; if (invuln !== 1'b0) begin n_err++; $display("FAIL rst_reinvuln_expire: got invuln=%b, expected 0", invuln); end
    endtask

    initial begin
        rst = 1'b1; x = '0; y = '0;
        frame_tick = 1'b0; hit = 1'b0; heal = 1'b0; restart = 1'b0;
        @(negedge clk);
        test_reset;
        test_invuln_timer;
        test_hits_to_death;
        test_priority;
        test_pixel_sweep;
        test_blink;
        test_restart_dead;
        test_rst_mid_invuln;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
